// File: rtl/psg_stereo_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : psg_stereo_mixer
//  Purpose  : Serial PSG channel mixer producing saturated stereo samples.
//  Revision : 1.0  initial release
// ============================================================================
module psg_stereo_mixer #(
  parameter int NCH   = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int SHIFT = 6
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ce_sample,
  input  logic [NCH*IN_W-1:0]   ch_in,
  input  logic [1:0]            mode,
  input  logic [2*NCH-1:0]      pan_map,
  output logic [OUT_W-1:0]      audio_l,
  output logic [OUT_W-1:0]      audio_r,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int ACC_W  = IN_W + $clog2(NCH + 1);
  localparam int IDX_W  = $clog2(NCH);
  localparam int WIDE_W = ACC_W + SHIFT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2
  } state_t;

  state_t               state;
  logic [NCH*IN_W-1:0]  snap;
  logic [1:0]           mode_q;
  logic [2*NCH-1:0]     pan_q;
  logic [IDX_W-1:0]     idx;
  logic [ACC_W-1:0]     acc_l;
  logic [ACC_W-1:0]     acc_r;

  logic [IN_W-1:0]      lvl;
  logic [1:0]           route;   // bit0 = left, bit1 = right
  logic [WIDE_W-1:0]    wide_l;
  logic [WIDE_W-1:0]    wide_r;
  logic [OUT_W-1:0]     sat_l;
  logic [OUT_W-1:0]     sat_r;

  assign lvl = snap[idx*IN_W +: IN_W];

  always_comb begin
    int unsigned ix;
    ix    = 32'(idx);
    route = 2'b11;
    case (mode_q)
      2'd1: begin
        if (ix == 0)      route = 2'b01;
        else if (ix == 2) route = 2'b10;
      end
      2'd2: begin
        if (ix == 0)      route = 2'b01;
        else if (ix == 1) route = 2'b10;
      end
      2'd3:    route = pan_q[2*idx +: 2];
      default: route = 2'b11;
    endcase
  end

  assign wide_l = WIDE_W'(acc_l) << SHIFT;
  assign wide_r = WIDE_W'(acc_r) << SHIFT;

  generate
    if (WIDE_W > OUT_W) begin : g_sat
      assign sat_l = (|wide_l[WIDE_W-1:OUT_W]) ? {OUT_W{1'b1}} : wide_l[OUT_W-1:0];
      assign sat_r = (|wide_r[WIDE_W-1:OUT_W]) ? {OUT_W{1'b1}} : wide_r[OUT_W-1:0];
    end else begin : g_nosat
      assign sat_l = OUT_W'(wide_l);
      assign sat_r = OUT_W'(wide_r);
    end
  endgenerate

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      snap      <= '0;
      mode_q    <= '0;
      pan_q     <= '0;
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      audio_l   <= '0;
      audio_r   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (ce_sample) begin
            snap   <= ch_in;
            mode_q <= mode;
            pan_q  <= pan_map;
            acc_l  <= '0;
            acc_r  <= '0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= ACC;
          end
        end
        ACC: begin
          overrun <= ce_sample;
          if (route[0]) acc_l <= acc_l + ACC_W'(lvl);
          if (route[1]) acc_r <= acc_r + ACC_W'(lvl);
          if (idx == LAST_IDX) state <= SCALE;
          else                 idx   <= idx + 1'b1;
        end
        SCALE: begin
          // A strobe landing on the final busy cycle is still an overrun.
          overrun   <= ce_sample;
          audio_l   <= sat_l;
          audio_r   <= sat_r;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psg_stereo_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psg_stereo_mixer
//  Purpose  : Self-checking bench for psg_stereo_mixer at SHIFT=6 and SHIFT=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_psg_stereo_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b0;
  logic [23:0] ch  = '0;
  logic [1:0]  mode = '0;
  logic [5:0]  pan  = '0;

  logic [15:0] l6, r6, l8, r8;
  logic        ov6, busy6, orun6, ov8, busy8, orun8;

  int checks = 0;
  int errors = 0;

  logic [31:0] q6[$];
  logic [31:0] q8[$];

  typedef struct {
    logic [1:0]  mode;
    logic [5:0]  pan;
    logic [23:0] ch;
    logic [15:0] l6, r6, l8, r8;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  psg_stereo_mixer #(.NCH(3), .IN_W(8), .OUT_W(16), .SHIFT(6)) dut6 (
    .clk_sys(clk), .reset(rst), .ce_sample(ce), .ch_in(ch), .mode(mode),
    .pan_map(pan), .audio_l(l6), .audio_r(r6), .out_valid(ov6),
    .busy(busy6), .overrun(orun6));

  psg_stereo_mixer #(.NCH(3), .IN_W(8), .OUT_W(16), .SHIFT(8)) dut8 (
    .clk_sys(clk), .reset(rst), .ce_sample(ce), .ch_in(ch), .mode(mode),
    .pan_map(pan), .audio_l(l8), .audio_r(r8), .out_valid(ov8),
    .busy(busy8), .overrun(orun8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every out_valid pops the oldest expected sample.
  always @(negedge clk) begin
    if (ov6) begin
      if (q6.size() == 0) chk("unexpected_out_valid6", 32'd1, 32'd0);
      else chk("sample6", {l6, r6}, q6.pop_front());
    end
    if (ov8) begin
      if (q8.size() == 0) chk("unexpected_out_valid8", 32'd1, 32'd0);
      else chk("sample8", {l8, r8}, q8.pop_front());
    end
  end

  task automatic drive(input vec_t v, input bit push);
    mode = v.mode;
    pan  = v.pan;
    ch   = v.ch;
    ce   = 1'b1;
    if (push) begin
      q6.push_back({v.l6, v.r6});
      q8.push_back({v.l8, v.r8});
    end
  endtask

  task automatic run_sample(input vec_t v);
    @(negedge clk);
    drive(v, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      ce = 1'b0;
      chk("busy", 32'(busy6), 32'(c <= 4));
      chk("out_valid", 32'(ov6), 32'(c == 5));
    end
    ch   = 24'($urandom);
    mode = 2'($urandom);
    repeat (3) @(negedge clk);
    chk("hold_l", 32'(l6), 32'(v.l6));
    chk("hold_r8", 32'(r8), 32'(v.r8));
  endtask

  initial begin
    vecs[0] = '{2'd1, 6'b000000, 24'h302010, 16'h0C00, 16'h1400, 16'h3000, 16'h5000};
    vecs[1] = '{2'd2, 6'b000000, 24'h302010, 16'h1000, 16'h1400, 16'h4000, 16'h5000};
    vecs[2] = '{2'd0, 6'b000000, 24'hFFFFFF, 16'hBF40, 16'hBF40, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{2'd3, 6'b001011, 24'h7F0201, 16'h0040, 16'h00C0, 16'h0100, 16'h0300};
    vecs[4] = '{2'd3, 6'b011001, 24'h302010, 16'h1000, 16'h0800, 16'h4000, 16'h2000};
    vecs[5] = '{2'd0, 6'b111111, 24'h000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[6] = '{2'd1, 6'b000000, 24'hFF0000, 16'h0000, 16'h3FC0, 16'h0000, 16'hFF00};

    repeat (3) @(negedge clk);
    chk("reset_audio", {l6, r6}, 32'd0);
    chk("reset_flags", {29'd0, ov6, busy6, orun6}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_sample(vecs[i]);

    // Overrun: second strobe at cycle 2 is ignored, mode change at cycle 1 not applied.
    @(negedge clk); drive(vecs[0], 1'b1);
    @(negedge clk); ce = 1'b0; mode = 2'd2;
    chk("overrun_c1", 32'(orun6), 32'd0);
    @(negedge clk); ce = 1'b1;
    chk("overrun_c2", 32'(orun6), 32'd0);
    @(negedge clk); ce = 1'b0;
    chk("overrun_c3", 32'(orun6), 32'd1);
    @(negedge clk);
    chk("overrun_c4", {30'd0, orun6, ov6}, 32'd0);
    @(negedge clk);
    chk("ovr_valid_c5", 32'(ov6), 32'd1);
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk);
      chk("ovr_single_valid", {30'd0, ov6, busy6}, 32'd0);
    end

    // Strobe on SCALE cycle is an overrun; strobe one cycle later is accepted.
    @(negedge clk); drive(vecs[2], 1'b1);
    @(negedge clk); ce = 1'b0;
    repeat (3) @(negedge clk);
    ce = 1'b1;
    @(negedge clk);
    chk("scale_overrun", {30'd0, orun6, ov6}, 32'd3);
    drive(vecs[3], 1'b1);
    @(negedge clk); ce = 1'b0;
    chk("accept_after_scale", 32'(busy6), 32'd1);
    repeat (4) @(negedge clk);
    chk("second_valid", 32'(ov6), 32'd1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a sample discards it.
    @(negedge clk); drive(vecs[0], 1'b0);
    @(negedge clk); ce = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("midreset_audio", {l6, r6, l8[15:8], r8[15:8]}, 32'd0);
    chk("midreset_busy", {30'd0, busy6, ov6}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("midreset_no_valid", {30'd0, ov6, ov8}, 32'd0);
    end
    run_sample(vecs[1]);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", q6.size() + q8.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
